// File: rtl/muldiv_if.sv
// muldiv_if
//   Handshake and data bundle for the iterative multiply/divide unit.
//   master : issuing side (pipeline / testbench) drives requests and MTHI/MTLO.
//   slave  : muldiv_unit, returns busy/done and the HI/LO contents.
// Signals
//   start, op[1:0], operand_1, operand_2 : operation request
//   flush                                : abort operation in flight
//   hi_write_en/hi_write_data            : MTHI
//   lo_write_en/lo_write_data            : MTLO
//   busy, done, hi_out, lo_out           : status and HI/LO registers
interface muldiv_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] operand_1;
  logic [DATA_WIDTH-1:0] operand_2;
  logic                  flush;
  logic                  hi_write_en;
  logic                  lo_write_en;
  logic [DATA_WIDTH-1:0] hi_write_data;
  logic [DATA_WIDTH-1:0] lo_write_data;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi_out;
  logic [DATA_WIDTH-1:0] lo_out;

  modport master (
    output start, op, operand_1, operand_2, flush,
           hi_write_en, lo_write_en, hi_write_data, lo_write_data,
    input  busy, done, hi_out, lo_out
  );

  modport slave (
    input  start, op, operand_1, operand_2, flush,
           hi_write_en, lo_write_en, hi_write_data, lo_write_data,
    output busy, done, hi_out, lo_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   MIPS-style HI/LO multiply/divide unit. Multiply is shift-add and divide is
//   restoring, one bit per cycle, working on operand magnitudes; sign
//   correction is applied in the FIX state before HI/LO are written.
//   op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
//   Latency: done at edge DATA_WIDTH+1 after the accepting edge; divide by
//   zero completes at edge 1 (LO = all ones, HI = dividend).
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : muldiv_if.slave (start/op/operands/flush/MTHI/MTLO in,
//          busy/done/hi_out/lo_out out)
// Configuration
//   MULDIV_FAST_MUL_EN : when defined, MULT/MULTU use a combinational
//                        multiplier and complete at edge 1. Divide unchanged.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int                    W        = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0]  CNT_INIT = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]          ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0]        ONE_2W   = {{(2*W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  // Two's-complement helpers. Magnitude of the most-negative value is
  // 2^(W-1), which is representable as an unsigned W-bit number.
  function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] v,
                                             input logic use_sign);
    logic [W-1:0] u;
    u = v;
    return (use_sign && v[W-1]) ? (~u + ONE_W) : u;
  endfunction

  function automatic logic [W-1:0] negate_w(input logic [W-1:0] v, input logic en);
    return en ? (~v + ONE_W) : v;
  endfunction

  function automatic logic [2*W-1:0] negate_2w(input logic [2*W-1:0] v, input logic en);
    return en ? (~v + ONE_2W) : v;
  endfunction

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [W-1:0]          hi_q, lo_q;
  logic                  done_q;

  // Datapath state: acc_q is {HI-half, LO-half}. Multiply: {partial, multiplier}.
  // Divide: {remainder, dividend/quotient}. Divide by zero: {dividend, -}.
  logic [2*W-1:0]        acc_q;
  logic [W-1:0]          opb_q;       // multiplicand or divisor magnitude
  logic                  is_div_q;
  logic                  div0_q;
  logic                  neg_lo_q;    // negate product / quotient
  logic                  neg_hi_q;    // negate remainder

  logic signed [W-1:0]   op1_s, op2_s;
  logic                  op_div, op_signed, divisor_zero, accept;
  logic [W-1:0]          mag1, mag2;

  assign op1_s        = bus.operand_1;
  assign op2_s        = bus.operand_2;
  assign op_div       = bus.op[1];
  assign op_signed    = ~bus.op[0];
  assign mag1         = magnitude(op1_s, op_signed);
  assign mag2         = magnitude(op2_s, op_signed);
  assign divisor_zero = (bus.operand_2 == '0);
  assign accept       = (state_q == IDLE) && bus.start && !bus.flush;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fast_prod;
  assign fast_prod = {{W{1'b0}}, mag1} * {{W{1'b0}}, mag2};
`endif

  // One shift-add step: add multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole accumulator right.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[W-1:1]};

  // One restoring-divide step: shift the next dividend bit into the
  // remainder and subtract the divisor if it fits. Remainder stays < divisor
  // so the trial value fits in W+1 bits.
  logic [W:0]     div_trial, div_diff;
  logic           div_fits;
  logic [2*W-1:0] div_next;
  assign div_trial = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff  = div_trial - {1'b0, opb_q};
  assign div_fits  = (div_trial >= {1'b0, opb_q});
  assign div_next  = div_fits ? {div_diff[W-1:0],  acc_q[W-2:0], 1'b1}
                              : {div_trial[W-1:0], acc_q[W-2:0], 1'b0};

  // Sign-corrected result presented while in FIX.
  logic [W-1:0]   fix_hi, fix_lo;
  logic [2*W-1:0] prod_fixed;
  always_comb begin
    fix_hi     = '0;
    fix_lo     = '0;
    prod_fixed = negate_2w(acc_q, neg_lo_q);
    if (div0_q) begin
      fix_hi = acc_q[2*W-1:W];
      fix_lo = '1;
    end else if (is_div_q) begin
      fix_hi = negate_w(acc_q[2*W-1:W], neg_hi_q);
      fix_lo = negate_w(acc_q[W-1:0],   neg_lo_q);
    end else begin
      fix_hi = prod_fixed[2*W-1:W];
      fix_lo = prod_fixed[W-1:0];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (op_div && divisor_zero) begin
              state_d = FIX;
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              state_d = op_div ? CALC : FIX;
`else
              state_d = CALC;
`endif
            end
          end
        end
        CALC:    if (cnt_q <= CNT_ONE) state_d = FIX;
        FIX:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and architectural registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == FIX) && !bus.flush;

      if (bus.flush)                cnt_q <= '0;
      else if (accept)              cnt_q <= CNT_INIT;
      else if (state_q == CALC)     cnt_q <= cnt_q - CNT_ONE;

      // MTHI/MTLO only while idle; a result can only land from FIX, so the
      // two writers never collide.
      if (state_q == FIX && !bus.flush) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end else if (state_q == IDLE) begin
        if (bus.hi_write_en) hi_q <= bus.hi_write_data;
        if (bus.lo_write_en) lo_q <= bus.lo_write_data;
      end
    end
  end

  // Datapath registers (no reset: contents are only consumed after a load)
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div_q <= op_div;
      div0_q   <= op_div && divisor_zero;
      neg_lo_q <= op_signed && (op1_s[W-1] ^ op2_s[W-1]);
      neg_hi_q <= op_signed && op1_s[W-1];
      if (op_div) begin
        opb_q <= mag2;
        acc_q <= divisor_zero ? {bus.operand_1, {W{1'b0}}} : {{W{1'b0}}, mag1};
      end else begin
        opb_q <= mag1;
`ifdef MULDIV_FAST_MUL_EN
        acc_q <= fast_prod;
`else
        acc_q <= {{W{1'b0}}, mag2};
`endif
      end
    end else if (state_q == CALC) begin
      acc_q <= is_div_q ? div_next : mul_next;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Directed vectors with literal expectations plus randomized traffic, all
//   compared every cycle against a transaction-level model of HI/LO, busy and
//   done (result = arithmetic definition of each op, applied after a fixed
//   latency).
module tb_muldiv_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_if #(.DATA_WIDTH(W)) bus ();

  muldiv_unit #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arithmetic definition of every op
  function automatic void ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = a;
    sb = b;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin sp = longint'(sa) * longint'(sb); {hi, lo} = sp; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; {hi, lo} = up; end
      2'b10: begin
        if (b == 0) begin hi = a; lo = '1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin hi = '0; lo = a; end
        else begin lo = sa / sb; hi = sa % sb; end
      end
      default: begin
        if (b == 0) begin hi = a; lo = '1; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endfunction

  function automatic int latency(input logic [1:0] op, input logic [W-1:0] b);
    if (op[1] && b == 0) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[1]) return 1;
`endif
    return W + 1;
  endfunction

  // Transaction-level model: cycles remaining until the pending result lands
  int          m_rem = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  logic        m_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    bit was_busy;
    if (rst) begin
      m_rem = 0; m_hi = '0; m_lo = '0; m_done = 1'b0;
    end else begin
      was_busy = (m_rem > 0);
      m_done   = 1'b0;
      if (!was_busy) begin
        if (bus.hi_write_en) m_hi = bus.hi_write_data;
        if (bus.lo_write_en) m_lo = bus.lo_write_data;
      end
      if (bus.flush) begin
        m_rem = 0;
      end else if (was_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = m_phi; m_lo = m_plo; m_done = 1'b1;
        end
      end else if (bus.start) begin
        ref_op(bus.op, bus.operand_1, bus.operand_2, m_phi, m_plo);
        m_rem = latency(bus.op, bus.operand_2);
      end
    end
  end

  // Compare process: every cycle, 1 time unit after the rising edge
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("busy", {31'd0, bus.busy}, {31'd0, (m_rem > 0)});
      check("done", {31'd0, bus.done}, {31'd0, m_done});
      check("hi",   bus.hi_out, m_hi);
      check("lo",   bus.lo_out, m_lo);
    end
  end

  task automatic idle_inputs();
    bus.start = 1'b0; bus.op = 2'b00; bus.operand_1 = '0; bus.operand_2 = '0;
    bus.flush = 1'b0; bus.hi_write_en = 1'b0; bus.lo_write_en = 1'b0;
    bus.hi_write_data = '0; bus.lo_write_data = '0;
  endtask

  // Issue one op, scramble operands after acceptance, return edges to done
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.operand_1 = a; bus.operand_2 = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.operand_1 = $urandom; bus.operand_2 = $urandom;
    lat = 0;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) break;
    end
  endtask

  task automatic start_only(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.operand_1 = a; bus.operand_2 = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 8)
      0: return '0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom % 32) - 32'd16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    bit saw_done;
    logic [W-1:0] h, l;

    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_hi", bus.hi_out, 32'd0);
    check("rst_lo", bus.lo_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Pin the reference model to hand-computed values
    ref_op(2'b00, 32'hFFFF_FFFD, 32'd5, h, l);
    check("model_mult_hi", h, 32'hFFFF_FFFF);
    check("model_mult_lo", l, 32'hFFFF_FFF1);
    ref_op(2'b10, 32'hFFFF_FFF9, 32'd2, h, l);
    check("model_div_hi", h, 32'hFFFF_FFFF);
    check("model_div_lo", l, 32'hFFFF_FFFD);
    ref_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l);
    check("model_multu_hi", h, 32'hFFFF_FFFE);
    check("model_multu_lo", l, 32'h0000_0001);

    // MULT -3 x 5
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, lat);
`ifdef MULDIV_FAST_MUL_EN
    check("mult_lat", 32'(lat), 32'd1);
`else
    check("mult_lat", 32'(lat), 32'd33);
`endif
    check("mult_hi", bus.hi_out, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo_out, 32'hFFFF_FFF1);

    run_op(2'b11, 32'd100, 32'd7, lat);
    check("divu_lat", 32'(lat), 32'd33);
    check("divu_lo", bus.lo_out, 32'h0000_000E);
    check("divu_hi", bus.hi_out, 32'h0000_0002);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat);
    check("div_lo", bus.lo_out, 32'hFFFF_FFFD);
    check("div_hi", bus.hi_out, 32'hFFFF_FFFF);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("divovf_lat", 32'(lat), 32'd33);
    check("divovf_lo", bus.lo_out, 32'h8000_0000);
    check("divovf_hi", bus.hi_out, 32'h0000_0000);

    run_op(2'b11, 32'd5, 32'd0, lat);
    check("div0_lat", 32'(lat), 32'd1);
    check("div0_lo", bus.lo_out, 32'hFFFF_FFFF);
    check("div0_hi", bus.hi_out, 32'h0000_0005);

`ifdef MULDIV_FAST_MUL_EN
    run_op(2'b00, 32'd7, 32'hFFFF_FFFE, lat);
    check("fast_lat", 32'(lat), 32'd1);
    check("fast_hi", bus.hi_out, 32'hFFFF_FFFF);
    check("fast_lo", bus.lo_out, 32'hFFFF_FFF2);
    run_op(2'b11, 32'd5, 32'd0, lat);
`endif

    // MULTU with flush raised after edge 10, sampled at edge 11
    start_only(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    check("flush_busy", {31'd0, bus.busy}, 32'd0);
    check("flush_hi", bus.hi_out, 32'h0000_0005);
    check("flush_lo", bus.lo_out, 32'hFFFF_FFFF);
    @(negedge clk);
    bus.flush = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (bus.done) saw_done = 1'b1; end
    check("flush_no_done", {31'd0, saw_done}, 32'd0);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("multu_hi", bus.hi_out, 32'hFFFF_FFFE);
    check("multu_lo", bus.lo_out, 32'h0000_0001);

    // Reset during DIV at edge 5
    start_only(2'b10, 32'd1000, 32'd3);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_hi", bus.hi_out, 32'd0);
    check("arst_lo", bus.lo_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (bus.done) saw_done = 1'b1; end
    check("arst_no_done", {31'd0, saw_done}, 32'd0);

    // MTHI while busy is dropped; MTHI while idle lands
    start_only(2'b01, 32'd3, 32'd4);
    bus.hi_write_en = 1'b1; bus.hi_write_data = 32'h0000_1234;
    @(posedge clk); #1;
    check("mthi_busy_hi", bus.hi_out, 32'd0);
    @(negedge clk);
    bus.hi_write_en = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("mul34_lo", bus.lo_out, 32'd12);
    @(negedge clk);
    bus.hi_write_en = 1'b1; bus.hi_write_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("mthi_idle_hi", bus.hi_out, 32'hDEAD_BEEF);
    @(negedge clk);
    bus.hi_write_en = 1'b0;

    // Randomized traffic; the compare process checks every cycle
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      bus.start         = ($urandom % 4) == 0;
      bus.op            = 2'($urandom);
      bus.operand_1     = pick();
      bus.operand_2     = pick();
      bus.flush         = ($urandom % 97) == 0;
      bus.hi_write_en   = ($urandom % 16) == 0;
      bus.lo_write_en   = ($urandom % 16) == 0;
      bus.hi_write_data = $urandom;
      bus.lo_write_data = $urandom;
    end
    @(negedge clk);
    idle_inputs();
    lat = 0;
    while (bus.busy && lat < 60) begin @(posedge clk); #1; lat++; end
    check("drain_idle", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
